// File: rtl/bus_loader_pkg.sv
// Shared opcodes and state encoding for the serial-command bus loader.
package bus_loader_pkg;

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    REQ  = 3'd3,
    ACC  = 3'd4,
    RESP = 3'd5
  } state_t;

endpackage

// File: rtl/bus_loader.sv
// Host-driven memory-bus initiator: parses 'W'/'R' byte commands, arbitrates
// with the CPU via bus_req/bus_gnt, performs the access and replies as bytes.
module bus_loader
  import bus_loader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [WIDTH-1:0] mbus_aout,
  output logic [WIDTH-1:0] mbus_dout,
  output logic             mbus_wen,
  input  logic [WIDTH-1:0] mbus_din,
  output logic             busy
);

  localparam int NB  = WIDTH / 8;
  localparam int BCW = $clog2(NB + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             is_wr_q, is_wr_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic [1:0]       lat_q, lat_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rx_fire;
  logic             last_byte;

  assign rx_ready  = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign busy      = (state_q != IDLE);
  assign rx_fire   = rx_valid && rx_ready;
  assign last_byte = (bcnt_q == BCW'(NB - 1));

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    bcnt_d    = bcnt_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    bus_req   = 1'b0;
    mbus_aout = '0;
    mbus_dout = '0;
    mbus_wen  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fire && (rx_data == CMD_W || rx_data == CMD_R)) begin
          is_wr_d = (rx_data == CMD_W);
          bcnt_d  = '0;
          tmo_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR, DATA: begin
        if (rx_fire) begin
          tmo_d = '0;
          if (state_q == ADDR) addr_d = (addr_q << 8) | WIDTH'(rx_data);
          else                 data_d = (data_q << 8) | WIDTH'(rx_data);
          if (last_byte) begin
            bcnt_d  = '0;
            state_d = (state_q == ADDR && is_wr_q) ? DATA : REQ;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
          // Host went quiet mid-command: drop it silently.
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          lat_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        bus_req   = 1'b1;
        mbus_aout = addr_q;
        if (is_wr_q) mbus_dout = data_q;
        // Losing the grant restarts the whole access from REQ.
        if (!bus_gnt) begin
          state_d = REQ;
        end else if (is_wr_q) begin
          mbus_wen = 1'b1;
          bcnt_d   = '0;
          state_d  = RESP;
        end else if (lat_q == 2'(RD_LAT)) begin
          data_d  = mbus_din;
          bcnt_d  = '0;
          state_d = RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      RESP: begin
        tx_valid = 1'b1;
        tx_data  = is_wr_q ? RSP_OK : data_q[WIDTH-1 -: 8];
        if (tx_ready) begin
          if (is_wr_q || last_byte) begin
            state_d = IDLE;
          end else begin
            data_d = data_q << 8;
            bcnt_d = bcnt_q + BCW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
    end
  end

  // Address/data holding registers need no reset: outputs are gated by state.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: tb/tb_bus_loader.sv
// Randomized bench for bus_loader with a command-level reference model.
module tb_bus_loader;

  localparam int WIDTH = 32;
  localparam int NB    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  wire              tx_ready;
  logic             bus_req;
  wire              bus_gnt;
  logic [WIDTH-1:0] mbus_aout;
  logic [WIDTH-1:0] mbus_dout;
  logic             mbus_wen;
  logic [WIDTH-1:0] mbus_din;
  logic             busy;

  bus_loader #(.WIDTH(WIDTH), .RD_LAT(1), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .mbus_aout(mbus_aout), .mbus_dout(mbus_dout), .mbus_wen(mbus_wen),
    .mbus_din(mbus_din), .busy(busy)
  );

  always #5 clk = ~clk;

  // Arbiter and transmitter: 0 = always ready, 1 = random, 2 = forced.
  int   gnt_mode = 0;
  logic gnt_force = 1'b0;
  logic gnt_rand = 1'b0;
  int   tx_mode = 0;
  logic tx_force = 1'b0;
  logic tx_rand = 1'b1;
  assign bus_gnt  = (gnt_mode == 0) ? 1'b1 : ((gnt_mode == 2) ? gnt_force : gnt_rand);
  assign tx_ready = (tx_mode == 0) ? 1'b1 : ((tx_mode == 2) ? tx_force : tx_rand);

  always @(negedge clk) begin
    gnt_rand <= bus_req && ($urandom_range(0, 3) != 0);
    tx_rand  <= ($urandom_range(0, 2) != 0);
  end

  // 16-word memory that ignores upper address bits, one-cycle read latency.
  function automatic logic [31:0] init_val(input int i);
    return (i == 0) ? 32'h12345678 : 32'(32'h9E3779B9 * 32'(i + 1));
  endfunction

  logic [15:0] bm_wr = '0;
  logic [31:0] bm_dat [16];
  logic [31:0] din_q = '0;
  int          nwrites = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  assign mbus_din = din_q;

  always @(posedge clk) begin
    din_q <= bm_wr[mbus_aout[3:0]] ? bm_dat[mbus_aout[3:0]] : init_val(int'(mbus_aout[3:0]));
    if (mbus_wen) begin
      bm_wr[mbus_aout[3:0]]  <= 1'b1;
      bm_dat[mbus_aout[3:0]] <= mbus_dout;
      nwrites <= nwrites + 1;
      last_wa <= mbus_aout;
      last_wd <= mbus_dout;
    end
  end

  // Reference model: expected memory contents, tx bytes and bus writes.
  logic [15:0] rm_wr = '0;
  logic [31:0] rm_dat [16];
  logic [7:0]  exp_tx [$];
  logic [63:0] exp_wr [$];
  logic [7:0]  rx_log [$];
  int          tx_head = 0;
  int          wr_head = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return rm_wr[a[3:0]] ? rm_dat[a[3:0]] : init_val(int'(a[3:0]));
  endfunction

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lit_q [$];
  int   lit_head = 0;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", n, a, e);
    end
  endtask

  // Single checking process: drains posted literal checks and watches the bus every cycle.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (lit_head < lit_q.size()) begin
        chk(lit_q[lit_head].name, lit_q[lit_head].act, lit_q[lit_head].exp);
        lit_head++;
      end
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (!bus_req) begin
          chk("aout_idle", mbus_aout, 32'h0);
          chk("dout_idle", mbus_dout, 32'h0);
          chk("wen_idle", 32'(mbus_wen), 32'h0);
        end
        if (bus_req || tx_valid) begin
          chk("rx_ready_blocked", 32'(rx_ready), 32'h0);
          chk("busy_active", 32'(busy), 32'h1);
        end
        if (tx_valid) chk("req_off_in_tx", 32'(bus_req), 32'h0);
        if (prev_hold) begin
          chk("tx_valid_held", 32'(tx_valid), 32'h1);
          chk("tx_data_stable", 32'(tx_data), 32'(prev_data));
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
        if (tx_valid && tx_ready) begin
          if (tx_head < exp_tx.size()) begin
            chk("tx_byte", 32'(tx_data), 32'(exp_tx[tx_head]));
            tx_head++;
          end else begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_tx: got 0x%02h, required no byte", tx_data);
          end
          rx_log.push_back(tx_data);
        end
        if (mbus_wen) begin
          chk("wen_needs_gnt", 32'(bus_gnt), 32'h1);
          if (wr_head < exp_wr.size()) begin
            chk("wr_addr", mbus_aout, exp_wr[wr_head][63:32]);
            chk("wr_data", mbus_dout, exp_wr[wr_head][31:0]);
            wr_head++;
          end else begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_write: got addr 0x%08h, required no write", mbus_aout);
          end
        end
      end
    end
  end

  task automatic post(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_q.push_back('{n, a, e});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) post("rx_accept_bound", 32'(k), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int maxgap);
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
  endtask

  task automatic issue_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input int maxgap);
    logic [31:0] v;
    if (w) begin
      exp_wr.push_back({a, d});
      rm_wr[a[3:0]]  = 1'b1;
      rm_dat[a[3:0]] = d;
      exp_tx.push_back(8'h4B);
    end else begin
      v = ref_read(a);
      for (int i = NB - 1; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
    end
    send_byte(w ? 8'h57 : 8'h52);
    for (int i = NB - 1; i >= 0; i--) begin
      gap(maxgap);
      send_byte(a[8*i +: 8]);
    end
    if (w) begin
      for (int i = NB - 1; i >= 0; i--) begin
        gap(maxgap);
        send_byte(d[8*i +: 8]);
      end
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((tx_head < exp_tx.size() || wr_head < exp_wr.size() || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    post("cmd_tx_done", 32'(tx_head), 32'(exp_tx.size()));
    post("cmd_wr_done", 32'(wr_head), 32'(exp_wr.size()));
    post("cmd_busy_end", 32'(busy), 32'h0);
  endtask

  task automatic post_reset_vals();
    post("rst_rx_ready", 32'(rx_ready), 32'h1);
    post("rst_tx_valid", 32'(tx_valid), 32'h0);
    post("rst_tx_data", 32'(tx_data), 32'h0);
    post("rst_bus_req", 32'(bus_req), 32'h0);
    post("rst_aout", mbus_aout, 32'h0);
    post("rst_dout", mbus_dout, 32'h0);
    post("rst_wen", 32'(mbus_wen), 32'h0);
    post("rst_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    int s, nw, bad, k;
    logic [7:0] g;
    #2;
    post_reset_vals();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Read with preloaded 0x12345678 at 0xF00.
    s = rx_log.size();
    issue_cmd(1'b0, 32'h00000F00, 32'h0, 0);
    wait_done();
    post("rd_b0", 32'(rx_log[s]),     32'h12);
    post("rd_b1", 32'(rx_log[s + 1]), 32'h34);
    post("rd_b2", 32'(rx_log[s + 2]), 32'h56);
    post("rd_b3", 32'(rx_log[s + 3]), 32'h78);

    // Write DEADBEEF to 0xF00 with grant tied high.
    @(negedge clk);
    nw = nwrites;
    s = rx_log.size();
    issue_cmd(1'b1, 32'h00000F00, 32'hDEADBEEF, 0);
    wait_done();
    post("wr_count", 32'(nwrites - nw), 32'd1);
    post("wr_last_addr", last_wa, 32'h00000F00);
    post("wr_last_data", last_wd, 32'hDEADBEEF);
    post("wr_reply", 32'(rx_log[s]), 32'h4B);

    // Grant withheld for 20 cycles after a complete write.
    @(negedge clk);
    gnt_mode  = 2;
    gnt_force = 1'b0;
    nw = nwrites;
    issue_cmd(1'b1, 32'h00000F04, 32'h0BADF00D, 0);
    bad = 0;
    repeat (20) begin
      if (!bus_req || mbus_wen) bad++;
      @(negedge clk);
    end
    post("gnt_wait_hold", 32'(bad), 32'd0);
    post("gnt_wait_nowrite", 32'(nwrites - nw), 32'd0);
    gnt_force = 1'b1;
    @(negedge clk);
    #1;
    post("gnt_then_wen", 32'(mbus_wen), 32'h1);
    post("gnt_then_aout", mbus_aout, 32'h00000F04);
    @(negedge clk);
    gnt_mode = 0;
    wait_done();

    // Timeout after a truncated write command.
    @(negedge clk);
    nw = nwrites;
    s = rx_log.size();
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (14) @(negedge clk);
    post("tmo_still_busy", 32'(busy), 32'h1);
    repeat (2) @(negedge clk);
    post("tmo_back_idle", 32'(busy), 32'h0);
    post("tmo_no_write", 32'(nwrites - nw), 32'd0);
    post("tmo_no_tx", 32'(rx_log.size() - s), 32'd0);
    issue_cmd(1'b0, 32'h00000F04, 32'h0, 0);
    wait_done();
    post("tmo_rd_b0", 32'(rx_log[s]),     32'h0B);
    post("tmo_rd_b3", 32'(rx_log[s + 3]), 32'h0D);

    // Garbage byte, then a read reply held off by the transmitter.
    @(negedge clk);
    tx_mode  = 2;
    tx_force = 1'b0;
    s = rx_log.size();
    send_byte(8'hAA);
    issue_cmd(1'b0, 32'h00000F00, 32'h0, 0);
    k = 0;
    while (!tx_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    post("bp_tx_valid", 32'(tx_valid), 32'h1);
    repeat (10) @(negedge clk);
    post("bp_nothing_sent", 32'(rx_log.size() - s), 32'd0);
    tx_force = 1'b1;
    wait_done();
    post("bp_b0", 32'(rx_log[s]),     32'hDE);
    post("bp_b1", 32'(rx_log[s + 1]), 32'hAD);
    post("bp_b2", 32'(rx_log[s + 2]), 32'hBE);
    post("bp_b3", 32'(rx_log[s + 3]), 32'hEF);
    tx_mode = 0;

    // Asynchronous reset on entry to the write access cycle.
    @(negedge clk);
    gnt_mode  = 2;
    gnt_force = 1'b0;
    nw = nwrites;
    send_byte(8'h57);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    send_byte(8'h09);
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hF0);
    send_byte(8'h0D);
    post("pre_rst_req", 32'(bus_req), 32'h1);
    gnt_force = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    post_reset_vals();
    @(negedge clk);
    gnt_force = 1'b0;
    gnt_mode  = 0;
    reset     = 1'b0;
    @(negedge clk);
    post("rst_no_write", 32'(nwrites - nw), 32'd0);
    issue_cmd(1'b0, 32'h00000009, 32'h0, 0);
    wait_done();

    // Randomized commands with random grant and transmitter behaviour.
    gnt_mode = 1;
    tx_mode  = 1;
    repeat (40) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        g = 8'($urandom);
        if (g == 8'h57 || g == 8'h52) g = 8'h11;
        send_byte(g);
      end
      issue_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 3);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/bus_loader.md
Name: bus_loader

Overview:
- Serial-command bus initiator. It turns a byte stream (from the uart receive side) into memory-bus reads and writes, and returns results as a byte stream (to the uart transmit side).
- It is the external, host-driven end of the memory bus, which the CPU normally drives. It is used for program loading and for peeking and poking memory or IO while the system runs.
- It arbitrates with the CPU through a request/grant pair. The top level muxes bus address, data and write-enable by bus_gnt.

Parameters:
- WIDTH, 32, bus word width. Must be a multiple of 8.
- RD_LAT, 1, cycles from address valid to mbus_din valid. Legal range 0..3.
- TIMEOUT, 1000000, maximum idle clk cycles between bytes of one command before the parser aborts.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  incoming byte valid
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- tx_valid  out  1  outgoing byte valid
- tx_data  out  8  outgoing byte
- tx_ready  in  1  transmitter accepts the byte
- bus_req  out  1  request bus ownership
- bus_gnt  in  1  ownership granted; the CPU is stalled while this is high
- mbus_aout  out  WIDTH  bus address
- mbus_dout  out  WIDTH  write data
- mbus_wen  out  1  write strobe
- mbus_din  in  WIDTH  read data from the top-level bus mux
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - rx_ready=1, tx_valid=0, tx_data=0, bus_req=0, mbus_aout=0, mbus_dout=0, mbus_wen=0, busy=0.
  - All counters cleared.
  - Reset mid-operation abandons the command. No write is issued if mbus_wen was not yet asserted.
- Byte transfer occurs when rx_valid && rx_ready, or tx_valid && tx_ready, at a rising clk edge.
- Command format, multi-byte fields MSB first, N = WIDTH/8:
  - 0x57 'W', then N address bytes, then N data bytes → bus write → reply 0x4B 'K'.
  - 0x52 'R', then N address bytes → bus read → reply N data bytes, MSB first.
  - Any other byte in IDLE is consumed and ignored. No reply.
- State machine:
  - IDLE: rx_ready=1. 'W' or 'R' latches the opcode, clears the byte count, and goes to ADDR.
  - ADDR: shift each byte into addr_reg (addr_reg = {addr_reg[WIDTH-9:0], byte}). After the Nth byte go to DATA for 'W', or to REQ for 'R'.
  - DATA: shift N bytes into data_reg, then go to REQ.
  - REQ: rx_ready=0, bus_req=1. Wait for bus_gnt=1, then go to ACC. There is no timeout in REQ.
  - ACC: bus_req stays 1. mbus_aout=addr_reg.
    - Write: mbus_dout=data_reg and mbus_wen=1 for exactly one cycle, then go to RESP.
    - Read: mbus_wen=0. mbus_din is captured into data_reg at the edge ending the (RD_LAT+1)th ACC cycle, then go to RESP.
  - RESP: bus_req=0 and bus outputs return to 0 on entry.
    - Write: send 0x4B.
    - Read: send data_reg bytes MSB first.
    - tx_valid is held, with tx_data stable, until tx_ready. Then go to IDLE.
- Bus ownership rule: the loader drives non-zero mbus_* only in ACC. It never asserts mbus_wen unless bus_gnt=1. If bus_gnt drops during ACC, the loader returns to REQ and restarts the access. For a read, data_reg is not updated before the restart.
- Timeout: in ADDR and DATA, a cycle counter counts cycles with no accepted byte and clears on each accepted byte. When it reaches TIMEOUT, the loader goes to IDLE with no reply and no bus access.
- rx_valid during REQ/ACC/RESP: not accepted (rx_ready=0). The upstream holds or drops the byte according to its own policy.
- busy=1 in every state except IDLE.
- The address is used as-is, with no alignment or masking. Address decode is done by the top-level address decoder.

Decomposition:
- Shared package: opcode constants CMD_W=8'h57, CMD_R=8'h52, RSP_OK=8'h4B, and the state encoding (IDLE, ADDR, DATA, REQ, ACC, RESP) as localparams.
- No sub-module. The byte counter and the timeout counter are inline. The uart itself stays outside; the top level connects uart rx/tx byte handshakes.

Test Plan:
- Write: bytes 57 00 00 0F 00 DE AD BE EF, with bus_gnt tied 1 → one cycle with mbus_wen=1, mbus_aout=0x00000F00, mbus_dout=0xDEADBEEF; then tx 4B; busy returns to 0.
- Read with RD_LAT=1: bytes 52 00 00 0F 00, memory model returns 0x12345678 one cycle after the address → tx bytes 12,34,56,78 in order; bus_req deasserts before the first tx_valid.
- Grant delay: bus_gnt held 0 for 20 cycles after a complete 'W' → bus_req=1 throughout, mbus_wen=0 throughout; the write occurs in the cycle after bus_gnt rises.
- Timeout: TIMEOUT=16; send 57 00 00, then idle 16 cycles → state IDLE, no tx, no write; a following valid 'R' command completes normally.
- Backpressure and garbage: send a leading 0xAA, then a read command, with tx_ready=0 for 10 cycles during the reply → 0xAA ignored; tx_data stable while tx_valid=1; all four bytes delivered; rx_ready=0 until the last byte is sent.
- Async reset asserted in ACC of a write before mbus_wen → mbus_wen never pulses; all outputs are at reset values immediately, without waiting for a clk edge.
